// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants, fetch state encoding and buffer entry type.
// Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Buffer sizing covers the largest legal DEPTH (4)
    localparam int FETCH_MAX_DEPTH = 4;
    localparam int FETCH_CNT_W     = 3;
    localparam int FETCH_PTR_W     = 2;

    localparam logic [0:0] FETCH_ST_FETCH = 1'b0;
    localparam logic [0:0] FETCH_ST_FLUSH = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : DEPTH-entry FIFO of {pc, inst} with push, pop and clear.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [XLEN-1:0]        i_push_pc,
    input  logic [XLEN-1:0]        i_push_inst,
    input  logic                   i_pop,
    output logic [XLEN-1:0]        o_head_pc,
    output logic [XLEN-1:0]        o_head_inst,
    output logic [FETCH_CNT_W-1:0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    fetch_entry_t               r_mem [FETCH_MAX_DEPTH];
    logic [FETCH_PTR_W-1:0]     r_rd_ptr;
    logic [FETCH_PTR_W-1:0]     r_wr_ptr;
    logic [FETCH_CNT_W-1:0]     r_count;
    logic                       w_do_push;
    logic                       w_do_pop;
    fetch_entry_t               w_head;

    function automatic logic [FETCH_PTR_W-1:0] next_ptr(input logic [FETCH_PTR_W-1:0] p);
        return (p == FETCH_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FETCH_CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign w_do_push = i_push & ~i_clear;
    assign w_do_pop  = i_pop & ~i_clear & ~o_empty;

    assign w_head      = r_mem[r_rd_ptr];
    assign o_head_pc   = w_head.pc;
    assign o_head_inst = w_head.inst;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            r_count <= r_count + FETCH_CNT_W'(w_do_push) - FETCH_CNT_W'(w_do_pop);
        end
    end

    // Payload storage needs no reset; validity is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= '{pc: i_push_pc, inst: i_push_inst};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Credit-based instruction fetch with redirect flush handling.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IF_ID_Stall,
    input  logic            Redirect,
    input  logic [XLEN-1:0] Redirect_PC,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instOut,
    output logic [XLEN-1:0] PC,
    output logic            inst_valid
);

    localparam int CW = FETCH_CNT_W;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [XLEN-1:0] w_redirect_pc;
    logic [CW-1:0]   w_inflight_after;
    logic [CW-1:0]   w_credit_used;
    logic [CW-1:0]   w_buf_count;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_inst;
    logic            w_buf_full;
    logic            w_buf_empty;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;

    assign w_redirect_pc    = align_word(Redirect_PC);
    assign w_inflight_after = r_outstanding - CW'(imem_rvalid);
    assign w_pop            = ~w_buf_empty & ~IF_ID_Stall & ~Redirect;
    // The entry leaving this cycle frees its credit now, which sustains one per cycle
    assign w_credit_used    = r_outstanding + w_buf_count - CW'(w_pop);
    assign w_accept         = imem_req & imem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH_ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (Redirect) begin
            w_state_next = (w_inflight_after != '0) ? FETCH_ST_FLUSH : FETCH_ST_FETCH;
        end else if ((r_state == FETCH_ST_FLUSH) && imem_rvalid && (r_drop_cnt == CW'(1))) begin
            w_state_next = FETCH_ST_FETCH;
        end
    end

    always_comb begin
        imem_req = 1'b0;
        w_push   = 1'b0;
        if (!rst && (r_state == FETCH_ST_FETCH) && !Redirect) begin
            imem_req = (w_credit_used < CW'(DEPTH)) && !(w_buf_full && !w_pop);
            w_push   = imem_rvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_rvalid);
            if (Redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_drop_cnt <= w_inflight_after;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                // Response PC follows request order rather than fetch_pc
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if ((r_state == FETCH_ST_FLUSH) && imem_rvalid) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (Redirect),
        .i_push      (w_push),
        .i_push_pc   (r_resp_pc),
        .i_push_inst (imem_rdata),
        .i_pop       (w_pop),
        .o_head_pc   (w_head_pc),
        .o_head_inst (w_head_inst),
        .o_count     (w_buf_count),
        .o_full      (w_buf_full),
        .o_empty     (w_buf_empty)
    );

    assign imem_addr  = r_fetch_pc;
    assign inst_valid = ~w_buf_empty;
    assign instOut    = w_buf_empty ? NOP_INST : w_head_inst;
    assign PC         = w_buf_empty ? '0 : w_head_pc;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 2, fetch-buffer entries (credits); legal values 2..4.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 IF_ID_Stall  input  1  IF/ID register holding; current instOut/PC not consumed this cycle.
REQ-006 Redirect  input  1  branch/jump taken; discard all fetched and in-flight instructions.
REQ-007 Redirect_PC  input  32  new fetch address, valid while Redirect=1.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  32  word-aligned request address.
REQ-010 imem_ready  input  1  memory accepts request this cycle (accept = imem_req & imem_ready).
REQ-011 imem_rvalid  input  1  read response valid; responses return in request order, >=1 cycle after accept.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 instOut  output  32  instruction presented to IF/ID register.
REQ-014 PC  output  32  address of instOut.
REQ-015 inst_valid  output  1  instOut/PC hold a real fetched instruction.

Function
REQ-016 fetch_pc register SHALL drive imem_addr; it increments by 4 on each accept, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 imem_req SHALL be 1 only when state=FETCH, Redirect=0, and (outstanding + buffer count) < DEPTH.
REQ-018 Each response accepted in FETCH SHALL be written to the buffer tail as {pc, rdata}; pc taken from an in-order address queue or counter, not recomputed from fetch_pc.
REQ-019 instOut/PC SHALL be the buffer head, registered (1 cycle after imem_rvalid at earliest); inst_valid=1 when buffer non-empty.
REQ-020 Buffer empty: instOut=32'h0000_0013 (NOP), PC=32'h0, inst_valid=0.
REQ-021 Head SHALL be popped when inst_valid=1 and IF_ID_Stall=0; IF_ID_Stall=1 holds head unchanged.
REQ-022 Simultaneous push and pop on a full buffer SHALL be legal; credit rule (REQ-017) guarantees no overflow, so a response never finds no space.
REQ-023 With 1-cycle memory, imem_ready=1 and no stall, sustained throughput SHALL be one instruction per cycle.
REQ-024 States: FETCH, FLUSH. FETCH -> FLUSH on Redirect when outstanding requests (excluding same-cycle accept, which is blocked) minus same-cycle response > 0; otherwise stay FETCH.
REQ-025 On Redirect (any state): fetch_pc <= Redirect_PC, buffer cleared, drop_cnt <= outstanding minus any response arriving that cycle; next-cycle inst_valid=0.
REQ-026 In FLUSH, each imem_rvalid SHALL decrement drop_cnt and be discarded; no requests issued; FLUSH -> FETCH when drop_cnt reaches 0 (request may issue the cycle after).
REQ-027 Redirect SHALL take priority over IF_ID_Stall; response arriving in the Redirect cycle SHALL be dropped.
REQ-028 Redirect_PC[1:0] SHALL be ignored (forced 0).

Reset
REQ-029 rst=1 SHALL set state=FETCH, fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, buffer empty, imem_req=0, outputs per REQ-020; first request in cycle after rst deasserts.
REQ-030 rst mid-operation SHALL abandon all in-flight requests; instruction memory shares rst, so no stale responses follow.

Structure
REQ-031 Shared package riscv_pkg SHALL hold XLEN=32, NOP_INST=32'h0000_0013, default RESET_PC, and the fetch state encoding.
REQ-032 Buffer SHALL be a sub-module fetch_buffer (DEPTH-entry FIFO, push/pop/clear, count, head, full/empty).

Verification
REQ-033 Reset, 1-cycle memory, ready=1, no stall -> addresses 0,4,8,... on consecutive cycles; inst_valid=1 from cycle 3; PC/instOut advance each cycle.
REQ-034 IF_ID_Stall=1 for 5 cycles with PC=0x10 at head -> instOut/PC held at 0x10; imem_req=0 once buffer+outstanding=2; resumes 0x14 after release.
REQ-035 Redirect to 0x200 with 2 requests outstanding (3-cycle memory) -> FLUSH, 2 responses dropped, no imem_req until drop_cnt=0, next valid PC=0x200.
REQ-036 Redirect same cycle as imem_rvalid and imem_ready=1 -> that response dropped, no request accepted, next inst_valid=0, first fetch at Redirect_PC.
REQ-037 imem_ready toggling 0/1 with random 1-4 cycle latency, 1000 instructions -> PC sequence strictly +4, no loss/duplication, no overflow.
REQ-038 rst asserted with 2 outstanding and buffer full -> next cycle inst_valid=0, imem_addr=RESET_PC, imem_req=0; fetch restarts at RESET_PC.
